// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: state encoding and
// oversampling geometry.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned HALF_BIT   = 8;
    localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally; pointers carry one extra bit so occupancy is wr - rd.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign level_o = wr_q - rd_q;
    assign full_o  = (level_o == FullLevel);
    assign empty_o = (wr_q == rd_q);

    // A pop frees the slot in the same cycle, so a push while full is accepted.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    assign pop_data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       baud_div,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_err,
    output logic                   overrun_err,
    output logic                   parity_err,
    input  logic                   err_clr
);

    localparam logic [3:0] OsLast   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] HalfLast = 4'(HALF_BIT - 1);
    localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

    rx_state_e        state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [3:0]       os_q, os_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic             tick, cnt_restart;
    logic             push, frame_set, overrun_set;
    logic             fifo_full, fifo_empty;
    logic             frame_err_q, overrun_err_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_set;
    logic             parity_err_q;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick  = (cnt_q == baud_div);
    assign cnt_d = (cnt_restart || tick) ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        os_d        = os_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        cnt_restart = 1'b0;
        push        = 1'b0;
        frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        parity_set  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // armed is only set by seeing the line high, so a held break never starts a frame
                if (rx_sync_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d     = START;
                    cnt_restart = 1'b1;
                    os_d        = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == HalfLast) begin
                        os_d  = '0;
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                        state_d = rx_sync_q ? IDLE : DATA;
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == OsLast) begin
                        os_d    = '0;
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if (os_q == OsLast) begin
                        os_d    = '0;
                        state_d = STOP;
                        if (^{shift_q, rx_sync_q}) begin
                            parity_set = 1'b1;
                            par_bad_d  = 1'b1;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (os_q == OsLast) begin
                        os_d    = '0;
                        state_d = IDLE;
                        if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
                            push = ~par_bad_q;
`else
                            push = 1'b1;
`endif
                        end else begin
                            frame_set = 1'b1;
                            armed_d   = 1'b0;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (rx_ready),
        .pop_data_o  (rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    assign rx_valid    = ~fifo_empty;
    assign overrun_set = push & fifo_full & ~rx_ready;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_set | (frame_err_q & ~err_clr);
            overrun_err_q <= overrun_set | (overrun_err_q & ~err_clr);
        end
    end

    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_set | (parity_err_q & ~err_clr);
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model of received bytes
// and sticky flags, compared against the DUT on every falling clock edge.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Tick index of the mid-bit sample of the stop and parity bits.
    localparam int STOP_MID = 8 + 16 * (NBITS - 1);
    localparam int PAR_MID  = 8 + 16 * 9;

    typedef struct {
        int unsigned at;
        logic [7:0]  b;
        bit          push;
        bit          frame;
        bit          par;
    } ev_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] baud_div = '0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [4:0]  level;
    logic        frame_err, overrun_err, parity_err;
    logic        err_clr = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          cmp_en = 1'b0;
    bit          rnd_en = 1'b0;

    logic [7:0]  mq[$];
    ev_t         evq[$];
    bit          m_frame = 1'b0, m_over = 1'b0, m_par = 1'b0;

    uart_rx_fifo #(
        .DEPTH (16),
        .DIV_W (16)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .rx          (rx),
        .baud_div    (baud_div),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .level       (level),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .err_clr     (err_clr)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // Drives one frame starting now and schedules its outcome in the model.
    task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_flip);
        int unsigned k;
        int          bt;
        ev_t         e;
`ifdef UART_RX_PARITY_EN
        logic        par;
        par = (^b) ^ par_flip;
`endif
        bt = 16 * (int'(baud_div) + 1);
        k  = cyc;
`ifdef UART_RX_PARITY_EN
        if (par_flip) begin
            e.at = k + 3 + PAR_MID * (int'(baud_div) + 1);
            e.b = b; e.push = 1'b0; e.frame = 1'b0; e.par = 1'b1;
            evq.push_back(e);
        end
`endif
        e.at    = k + 3 + STOP_MID * (int'(baud_div) + 1);
        e.b     = b;
        e.push  = stop_ok && !par_flip;
        e.frame = !stop_ok;
        e.par   = 1'b0;
        evq.push_back(e);
        rx = 1'b0;
        wait_cyc(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(bt);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_cyc(bt);
`endif
        rx = stop_ok;
        wait_cyc(bt);
    endtask

    // Model: FIFO contents as a queue, flags as bits, updated at each edge.
    initial begin
        ev_t e;
        bit  set_f, set_o, set_p;
        forever begin
            @(posedge wb_clk_i);
            cyc++;
            if (wb_rst_i) begin
                mq.delete();
                evq.delete();
                m_frame = 1'b0;
                m_over  = 1'b0;
                m_par   = 1'b0;
            end else begin
                set_f = 1'b0;
                set_o = 1'b0;
                set_p = 1'b0;
                if (rx_ready && mq.size() > 0) void'(mq.pop_front());
                while (evq.size() > 0 && evq[0].at <= cyc) begin
                    e = evq.pop_front();
                    if (e.par) set_p = 1'b1;
                    if (e.frame) set_f = 1'b1;
                    if (e.push) begin
                        if (mq.size() >= DEPTH) set_o = 1'b1;
                        else mq.push_back(e.b);
                    end
                end
                m_frame = set_f || (m_frame && !err_clr);
                m_over  = set_o || (m_over && !err_clr);
                m_par   = set_p || (m_par && !err_clr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (cmp_en) begin
                chk("valid", rx_valid, mq.size() > 0);
                chk("level", level, mq.size());
                if (mq.size() > 0) chk("data", rx_data, mq[0]);
                chk("frame_err", frame_err, m_frame);
                chk("overrun_err", overrun_err, m_over);
                chk("parity_err", parity_err, m_par);
            end
        end
    end

    initial begin
        forever begin
            @(posedge wb_clk_i);
            #2;
            if (rnd_en) begin
                rx_ready = 1'($urandom_range(0, 1));
                err_clr  = ($urandom_range(0, 15) == 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        bit         ok;

        wait_cyc(1);
        cmp_en = 1'b1;
        wait_cyc(2);
        wb_rst_i = 1'b0;
        chk("rst_valid", rx_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_flags", {frame_err, overrun_err, parity_err}, 0);
        wait_cyc(10);

        // Single byte, with push timing pinned around the stop sample.
        fork
            send(8'h48, 1'b1, 1'b0);
            begin
                wait_cyc(STOP_MID + 2);
                chk("pre_push_valid", rx_valid, 0);
                wait_cyc(1);
                chk("push_valid", rx_valid, 1);
                chk("push_data", rx_data, 8'h48);
                chk("push_level", level, 1);
            end
        join
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        chk("pop_valid", rx_valid, 0);

        // Short glitch is rejected.
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(40);
        chk("glitch_level", level, 0);
        chk("glitch_flags", {frame_err, overrun_err, parity_err}, 0);

        // Framing error, break, then a good frame.
        send(8'h55, 1'b0, 1'b0);
        chk("ferr_set", frame_err, 1);
        chk("ferr_level", level, 0);
        wait_cyc(40);
        rx = 1'b1;
        wait_cyc(20);
        send(8'h41, 1'b1, 1'b0);
        chk("brk_level", level, 1);
        chk("brk_data", rx_data, 8'h41);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        chk("ferr_clr", frame_err, 0);

        // Overrun: 17 back-to-back bytes into a 16-entry FIFO.
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b1, 1'b0);
        chk("ovr_level", level, 16);
        chk("ovr_flag", overrun_err, 1);
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovr_order", rx_data, i);
            wait_cyc(1);
        end
        rx_ready = 1'b0;
        chk("ovr_drained", rx_valid, 0);

        // Reset in the middle of a frame with a byte queued and a flag set.
        send(8'h99, 1'b1, 1'b0);
        chk("pre_rst_level", level, 1);
        fork
            send(8'hF8, 1'b1, 1'b0);
            begin
                wait_cyc(16 * 4 + 6);
                wb_rst_i = 1'b1;
                wait_cyc(1);
                wb_rst_i = 1'b0;
                chk("mid_rst_level", level, 0);
                chk("mid_rst_valid", rx_valid, 0);
                chk("mid_rst_data", rx_data, 0);
                chk("mid_rst_flags", {frame_err, overrun_err, parity_err}, 0);
            end
        join
        wait_cyc(10);
        send(8'h7E, 1'b1, 1'b0);
        chk("post_rst_data", rx_data, 8'h7E);
        chk("post_rst_level", level, 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b1);
        chk("par_bad_flag", parity_err, 1);
        chk("par_bad_level", level, 0);
        send(8'h03, 1'b1, 1'b0);
        chk("par_ok_data", rx_data, 8'h03);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
`endif

        // Randomized frames, divisors, consumer stalls and flag clears.
        rnd_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) baud_div = 16'($urandom_range(0, 3));
            send(rb, ok, 1'b0);
            if (!ok) begin
                rx = 1'b1;
                wait_cyc(8);
            end else begin
                wait_cyc($urandom_range(0, 2));
            end
        end
        rnd_en = 1'b0;
        wait_cyc(1);
        err_clr  = 1'b0;
        rx_ready = 1'b1;
        wait_cyc(20);
        chk("final_empty", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
